// File: rtl/mp_arith_pkg.sv
// Shared types and constants for the multi-precision add/subtract sequencer.
package mp_arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned BYTE_W = 8;

   // Byte index width: max(1, clog2(words)).
   function automatic int unsigned calc_idxw(input int unsigned words);
      return (words <= 2) ? 1 : $clog2(words);
   endfunction

endpackage

// File: rtl/adder8_core.sv
// 8-bit ripple-carry adder shared by all byte lanes.
module adder8_core (
   output logic [7:0] S,
   output logic       Cout,
   input  logic [7:0] X,
   input  logic [7:0] Y,
   input  logic       Cin
);

   logic [8:0] c;

   assign c[0] = Cin;

   // One full adder per bit, carry rippling upward.
   for (genvar i = 0; i < 8; i++) begin : g_fa
      assign S[i]   = X[i] ^ Y[i] ^ c[i];
      assign c[i+1] = (X[i] & Y[i]) | (c[i] & (X[i] ^ Y[i]));
   end

   assign Cout = c[8];

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract: one byte pair per cycle through a shared 8-bit adder.
module mp_add_seq
   import mp_arith_pkg::*;
#(
   parameter int unsigned WORDS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    sub,
   input  logic [WORDS*BYTE_W-1:0] a_in,
   input  logic [WORDS*BYTE_W-1:0] b_in,
   output logic [WORDS*BYTE_W-1:0] sum_out,
   output logic                    cout,
   output logic                    ovf,
   output logic                    busy,
   output logic                    done
);

   localparam int unsigned IDXW = calc_idxw(WORDS);
   localparam int unsigned W    = WORDS * BYTE_W;
   localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

   state_t            state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic              carry_q, carry_d;
   logic              sub_q, sub_d;
   logic [W-1:0]      a_q, a_d;
   logic [W-1:0]      b_q, b_d;
   logic [W-1:0]      sum_d;
   logic              cout_d, ovf_d, busy_d, done_d;

   logic [BYTE_W-1:0] x, y, s;
   logic              co;

   // Current byte lane; B is inverted for subtract (carry-in supplies the +1).
   always_comb begin
      x = a_q[idx_q*BYTE_W +: BYTE_W];
      y = b_q[idx_q*BYTE_W +: BYTE_W] ^ {BYTE_W{sub_q}};
   end

   adder8_core u_adder (
      .S    (s),
      .Cout (co),
      .X    (x),
      .Y    (y),
      .Cin  (carry_q)
   );

   // Next-state and next-output logic.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      sub_d   = sub_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_out;
      cout_d  = cout;
      ovf_d   = ovf;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a_in;
               b_d     = b_in;
               sub_d   = sub;
               carry_d = sub;
               sum_d   = '0;
               cout_d  = 1'b0;
               ovf_d   = 1'b0;
               idx_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            busy_d                           = 1'b1;
            sum_d[idx_q*BYTE_W +: BYTE_W]    = s;
            carry_d                          = co;
            if (idx_q == LAST) begin
               cout_d  = co;
               ovf_d   = x[BYTE_W-1] ^ y[BYTE_W-1] ^ s[BYTE_W-1] ^ co;
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               idx_d = idx_q + IDXW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         sub_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_out <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         sub_q   <= sub_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_out <= sum_d;
         cout    <= cout_d;
         ovf     <= ovf_d;
         busy    <= busy_d;
         done    <= done_d;
      end
   end

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq (WORDS=4 and WORDS=1 instances).
module tb_mp_add_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start4, start1, sub;
   logic [31:0] a_in, b_in;
   logic [31:0] sum4;
   logic [7:0]  sum1;
   logic        cout4, ovf4, busy4, done4;
   logic        cout1, ovf1, busy1, done1;

   int checks = 0;
   int errors = 0;
   bit use1   = 1'b0;

   always #5 clk = ~clk;

   mp_add_seq #(.WORDS(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .sub(sub),
      .a_in(a_in), .b_in(b_in), .sum_out(sum4),
      .cout(cout4), .ovf(ovf4), .busy(busy4), .done(done4)
   );

   mp_add_seq #(.WORDS(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .sub(sub),
      .a_in(a_in[7:0]), .b_in(b_in[7:0]), .sum_out(sum1),
      .cout(cout1), .ovf(ovf1), .busy(busy1), .done(done1)
   );

   wire [31:0] sum_s  = use1 ? {24'd0, sum1} : sum4;
   wire        cout_s = use1 ? cout1 : cout4;
   wire        ovf_s  = use1 ? ovf1  : ovf4;
   wire        busy_s = use1 ? busy1 : busy4;
   wire        done_s = use1 ? done1 : done4;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: plain modular arithmetic and sign rules on w-byte operands.
   task automatic model(input int w, input logic [31:0] a, input logic [31:0] b, input bit s,
                        output logic [31:0] sum, output bit c, output bit o);
      longint unsigned mask, au, bu, full, r;
      bit sa, sb, sr;
      mask = (64'd1 << (w * 8)) - 64'd1;
      au   = {32'd0, a} & mask;
      bu   = {32'd0, b} & mask;
      if (!s) begin
         full = au + bu;
         r    = full & mask;
         c    = ((full >> (w * 8)) & 64'd1) != 0;
      end else begin
         r = (au - bu) & mask;
         c = (au >= bu);
      end
      sum = 32'(r);
      sa  = ((au >> (w * 8 - 1)) & 64'd1) != 0;
      sb  = ((bu >> (w * 8 - 1)) & 64'd1) != 0;
      sr  = ((r  >> (w * 8 - 1)) & 64'd1) != 0;
      o   = s ? (sa != sb && sr != sa) : (sa == sb && sr != sa);
   endtask

   // Issue one operation (caller is between edges), check latency, result and pulse width.
   task automatic run_op(input bit one, input logic [31:0] a, input logic [31:0] b, input bit s,
                         input string tag);
      logic [31:0] es;
      bit ec, eo, seen;
      int w, lat;
      use1 = one;
      w    = one ? 1 : 4;
      model(w, a, b, s, es, ec, eo);
      a_in = a; b_in = b; sub = s;
      if (one) start1 = 1'b1; else start4 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0; start4 = 1'b0;
      a_in = $urandom; b_in = $urandom; sub = 1'($urandom);
      seen = 1'b0; lat = 0;
      for (int n = 1; n <= 40 && !seen; n++) begin
         @(negedge clk);
         if (n == 1) check({tag, " busy_run"}, 32'(busy_s), 32'd1);
         if (done_s) begin
            seen = 1'b1;
            lat  = n;
         end
      end
      check({tag, " latency"}, 32'(lat), 32'(w + 1));
      if (seen) begin
         check({tag, " sum"},  sum_s, es);
         check({tag, " cout"}, 32'(cout_s), 32'(ec));
         check({tag, " ovf"},  32'(ovf_s),  32'(eo));
         check({tag, " busy_done"}, 32'(busy_s), 32'd1);
         @(negedge clk);
         check({tag, " done_pulse"}, 32'(done_s), 32'd0);
         check({tag, " busy_after"}, 32'(busy_s), 32'd0);
      end
   endtask

   initial begin
      int ndone, done_at;
      logic [31:0] ra, rb;
      rst = 1'b1; start4 = 1'b0; start1 = 1'b0; sub = 1'b0;
      a_in = '0; b_in = '0;
      repeat (3) @(negedge clk);
      check("rst sum4", sum4, 32'd0);
      check("rst cout4", 32'(cout4), 32'd0);
      check("rst ovf4", 32'(ovf4), 32'd0);
      check("rst busy4", 32'(busy4), 32'd0);
      check("rst done4", 32'(done4), 32'd0);
      check("rst sum1", 32'(sum1), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed cases.
      run_op(0, 32'h000000FF, 32'h00000001, 0, "t1");
      @(negedge clk);
      run_op(0, 32'hFFFFFFFF, 32'h00000001, 0, "t2");
      @(negedge clk);
      run_op(0, 32'h7FFFFFFF, 32'h00000001, 0, "t3a");
      @(negedge clk);
      run_op(0, 32'h00000000, 32'h00000001, 1, "t3b");
      @(negedge clk);
      run_op(0, 32'h80000000, 32'h00000001, 1, "subovf");

      // Starts during RUN and DONE are ignored.
      use1 = 1'b0;
      @(negedge clk);
      a_in = 32'h11111111; b_in = 32'h22222222; sub = 1'b0; start4 = 1'b1;
      @(posedge clk);
      #1 start4 = 1'b0;
      ndone = 0; done_at = 0;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         if (done4) begin
            ndone++;
            done_at = n;
         end
         if (n == 6) check("t4 busy_after", 32'(busy4), 32'd0);
         start4 = 1'b0;
         if (n == 2 || n == 5) begin
            a_in = 32'hFFFFFFFF; b_in = 32'hFFFFFFFF; sub = 1'b1; start4 = 1'b1;
         end
      end
      check("t4 ndone", 32'(ndone), 32'd1);
      check("t4 done_at", 32'(done_at), 32'd5);
      check("t4 sum", sum4, 32'h33333333);
      check("t4 cout", 32'(cout4), 32'd0);
      check("t4 busy_end", 32'(busy4), 32'd0);

      // Asynchronous reset in RUN at byte index 2.
      @(negedge clk);
      a_in = 32'h12345678; b_in = 32'h11111111; sub = 1'b0; start4 = 1'b1;
      @(posedge clk);
      #1 start4 = 1'b0;
      repeat (3) @(negedge clk);
      check("t5 busy_pre", 32'(busy4), 32'd1);
      check("t5 partial", sum4, 32'h00006789);
      #2 rst = 1'b1;
      #1;
      check("t5 rst sum", sum4, 32'd0);
      check("t5 rst busy", 32'(busy4), 32'd0);
      check("t5 rst done", 32'(done4), 32'd0);
      check("t5 rst cout", 32'(cout4), 32'd0);
      ndone = 0;
      repeat (3) begin
         @(negedge clk);
         if (done4) ndone++;
      end
      check("t5 no_done", 32'(ndone), 32'd0);
      rst = 1'b0;
      run_op(0, 32'h00000005, 32'h00000003, 1, "t5");

      // Single-byte instance.
      @(negedge clk);
      run_op(1, 32'h00000080, 32'h00000080, 0, "t6");
      @(negedge clk);
      run_op(1, 32'h0000007F, 32'h000000FF, 1, "t6sub");

      // Randomized operations against the reference.
      for (int i = 0; i < 20; i++) begin
         ra = $urandom; rb = $urandom;
         if (i % 5 == 0) ra = 32'h7FFFFFFF;
         if (i % 7 == 0) rb = ra;
         @(negedge clk);
         run_op(0, ra, rb, 1'($urandom), "rand4");
      end
      for (int i = 0; i < 10; i++) begin
         ra = $urandom; rb = $urandom;
         @(negedge clk);
         run_op(1, ra, rb, 1'($urandom), "rand1");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mp_add_seq.md
Name: mp_add_seq

Overview:
Multi-precision add/subtract sequencer that time-shares one 8-bit ripple-carry adder across WORDS byte lanes.
- Latches two WORDS*8-bit operands on a start handshake.
- Feeds one byte pair per cycle, LSB byte first, through the adder and holds the inter-byte carry in a register.
- Reports sum, carry-out and signed overflow with a one-cycle done pulse.
- Sits between the control logic issuing wide arithmetic requests and the 8-bit adder datapath.

Parameters:
WORDS, 4, number of 8-bit bytes per operand; legal range 1..16.
IDXW, derived as max(1, clog2(WORDS)), width of the byte index counter; not for override.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only when busy=0.
sub  input  1  0 = A+B, 1 = A-B; latched with start.
a_in  input  WORDS*8  operand A, latched on accepted start.
b_in  input  WORDS*8  operand B, latched on accepted start.
sum_out  output  WORDS*8  result; holds until the next accepted start or reset.
cout  output  1  final carry out of the top byte; for subtract, 1 = no borrow.
ovf  output  1  two's-complement overflow of the full-width result.
busy  output  1  high in RUN and DONE.
done  output  1  single-cycle pulse; result valid.

Behaviour:
- Reset (async assert, sync release) values: state=IDLE, idx=0, carry=0, operand registers=0, sum_out=0, cout=0, ovf=0, busy=0, done=0.
- IDLE:
  - If start=1 at a rising edge: latch a_in, b_in and sub; set carry to sub; clear sum_out, cout and ovf; set idx=0; go to RUN.
  - Otherwise stay in IDLE.
- RUN, one byte per edge:
  - Adder inputs: X=A[idx*8+:8], Y=B[idx*8+:8] XOR {8{sub}}, Cin=carry.
  - At each edge: write S into sum_out[idx*8+:8], load adder Cout into carry, increment idx.
  - At the edge where idx==WORDS-1:
    - cout is loaded from adder Cout.
    - ovf is loaded as (carry into bit 7) XOR Cout, where carry into bit 7 = X[7]^Y[7]^S[7].
    - Next state is DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE at the next edge.
  - busy stays high during DONE.
- Latency: start sampled at edge k means done=1 in the cycle following edge k+WORDS, so it is sampled high at edge k+WORDS+1. Throughput is one operation per WORDS+2 cycles.
- busy=1 from the cycle after an accepted start through the DONE cycle.
- start while busy=1 (including the DONE cycle) is ignored: not queued, and operands are not re-latched.
- a_in, b_in and sub may change freely after acceptance; only latched copies are used.
- sum_out bytes not yet written read 0 during RUN. Consumers use sum_out only when done=1 or later.
- Index wrap: idx never exceeds WORDS-1; it is cleared on entry to RUN.
- WORDS=1: a single RUN cycle, then DONE.
- Reset mid-RUN or mid-DONE:
  - Immediate return to reset values.
  - Partial results are discarded and done does not pulse.
  - A new start is accepted at the first edge after rst deasserts.
- Arithmetic is modulo 2^(WORDS*8). For subtract, carry-in 1 plus inverted B forms two's complement.

Decomposition:
- Shared package mp_arith_pkg holds:
  - state encoding typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - constant BYTE_W=8;
  - a function computing IDXW from WORDS.
- One sub-module is natural: adder8_core, the 8-bit ripple-carry adder with ports (S[7:0], Cout, X[7:0], Y[7:0], Cin), instantiated once.
- The sequencer holds the FSM, index counter, carry register, operand and result registers, and the XOR inversion.

Test Plan:
1. WORDS=4, A=0x000000FF, B=0x00000001, sub=0, start at edge k -> done=1 at edge k+5; sum_out=0x00000100, cout=0, ovf=0.
2. A=0xFFFFFFFF, B=0x00000001, sub=0 -> sum_out=0x00000000, cout=1, ovf=0 (full carry ripple across all bytes).
3. A=0x7FFFFFFF, B=0x00000001, sub=0 -> sum_out=0x80000000, cout=0, ovf=1. Then A=0x00000000, B=0x00000001, sub=1 -> sum_out=0xFFFFFFFF, cout=0 (borrow), ovf=0.
4. Start A=0x11111111+B=0x22222222, then assert start with A=0xFFFFFFFF at RUN idx=1 and again in DONE -> ignored. Result is 0x33333333 with exactly one done pulse; busy=0 the cycle after done.
5. Assert rst asynchronously at RUN idx=2 -> all outputs 0 immediately with no done pulse. After release, start 0x00000005-0x00000003 -> sum_out=0x00000002, cout=1, ovf=0.
6. WORDS=1, A=0x80, B=0x80, sub=0 -> done sampled at edge k+2, sum_out=0x00, cout=1, ovf=1.
